// File: rtl/rrf_alloc_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// rrf_alloc_ctrl_pkg
//   Shared constants and types for the rename register file (RRF) allocation
//   controller: default entry count and tag width, the controller FSM state
//   encoding and a small helper that counts a pair of valid bits.
// ----------------------------------------------------------------------------
package rrf_alloc_ctrl_pkg;

    localparam int unsigned RrfNumDefault = 64;
    localparam int unsigned RrfSelDefault = 6;

    typedef enum logic [0:0] {
        StRun     = 1'b0,
        StRecover = 1'b1
    } rrf_state_e;

    // Number of asserted bits in a two-slot request/commit pair (0..2).
    function automatic logic [1:0] count2(input logic a, input logic b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/rrf_alloc_ctrl.sv
// ----------------------------------------------------------------------------
// rrf_alloc_ctrl
//   Allocation controller for the rename register file. Hands out up to two
//   tags per cycle from a circular allocation pointer, frees entries on
//   in-order commit, stalls dispatch when entries run short and sequences
//   flush recovery (one-cycle rename-table clear pulse).
//
//   Ports:
//     clk, rst            clock, asynchronous active-high reset
//     i_dp_req_1/2        dispatch slot requests (slot 2 only with slot 1)
//     o_dp_ptr_1/2        tags offered to slots 1/2
//     o_dp_stall          requests present but not granted this cycle
//     i_com_vld_1/2       oldest / second-oldest entries commit
//     o_com_ptr           tag of the oldest in-flight entry
//     i_flush             squash all in-flight entries
//     o_rt_flush          one-cycle pulse clearing rename-table busy bits
//     o_free_cnt          number of free entries
//     o_empty             no entry in flight
//     o_err               sticky protocol error
//
//   Optional feature (macro RRF_ALLOC_PERF_CNT_EN):
//     o_stall_cycles[31:0] saturating count of cycles with o_dp_stall high
//     o_flush_cnt[15:0]    saturating count of accepted flushes
// ----------------------------------------------------------------------------
module rrf_alloc_ctrl
    import rrf_alloc_ctrl_pkg::*;
#(
    parameter int unsigned RrfNum = RrfNumDefault,
    parameter int unsigned RrfSel = RrfSelDefault
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_dp_req_1,
    input  logic              i_dp_req_2,
    output logic [RrfSel-1:0] o_dp_ptr_1,
    output logic [RrfSel-1:0] o_dp_ptr_2,
    output logic              o_dp_stall,
    input  logic              i_com_vld_1,
    input  logic              i_com_vld_2,
    output logic [RrfSel-1:0] o_com_ptr,
    input  logic              i_flush,
    output logic              o_rt_flush,
    output logic [RrfSel:0]   o_free_cnt,
    output logic              o_empty,
`ifdef RRF_ALLOC_PERF_CNT_EN
    output logic [31:0]       o_stall_cycles,
    output logic [15:0]       o_flush_cnt,
`endif
    output logic              o_err
);

    localparam int unsigned CntW = RrfSel + 1;
    localparam logic [CntW-1:0] NumEnt = CntW'(RrfNum);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [RrfSel-1:0] alloc_ptr_q, alloc_ptr_d;
    logic [RrfSel-1:0] com_ptr_q, com_ptr_d;
    logic [CntW-1:0]   free_cnt_q, free_cnt_d;
    rrf_state_e        state_q, state_d;
    logic              rt_flush_q, rt_flush_d;
    logic              err_q, err_d;

    // ------------------------------------------------------------------
    // Request / grant / commit decode
    // ------------------------------------------------------------------
    logic [1:0]      n_req;
    logic [1:0]      n_com;
    logic [1:0]      n_alloc;
    logic [CntW-1:0] in_flight;
    logic            granted;
    logic            over_com;
    logic            proto_err;
    logic            flush_take;

    assign n_req     = count2(i_dp_req_1, i_dp_req_2);
    assign n_com     = count2(i_com_vld_1, i_com_vld_2);
    assign in_flight = NumEnt - free_cnt_q;

    // Grant uses the registered free count only; same-cycle commits are
    // credited from the next cycle on.
    assign granted = (state_q == StRun) && !i_flush && (free_cnt_q >= CntW'(n_req));
    assign n_alloc = granted ? n_req : 2'd0;

    assign over_com  = CntW'(n_com) > in_flight;
    assign proto_err = over_com
                     | (i_dp_req_2 & ~i_dp_req_1)
                     | (i_com_vld_2 & ~i_com_vld_1);

    // A flush raised while already recovering does not re-pulse the clear.
    assign flush_take = i_flush && (state_q == StRun) && !over_com;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        alloc_ptr_d = alloc_ptr_q;
        com_ptr_d   = com_ptr_q;
        free_cnt_d  = free_cnt_q;
        state_d     = state_q;
        rt_flush_d  = 1'b0;
        err_d       = err_q | proto_err;

        // An over-commit freezes pointers, count and FSM; only o_err moves.
        if (!over_com) begin
            com_ptr_d  = com_ptr_q + RrfSel'(n_com);
            rt_flush_d = flush_take;
            if (i_flush) begin
                // Everything younger than the committing entries is squashed.
                alloc_ptr_d = com_ptr_q + RrfSel'(n_com);
                free_cnt_d  = NumEnt;
                state_d     = StRecover;
            end else begin
                alloc_ptr_d = alloc_ptr_q + RrfSel'(n_alloc);
                free_cnt_d  = free_cnt_q - CntW'(n_alloc) + CntW'(n_com);
                state_d     = StRun;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers (pointers, count and FSM)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alloc_ptr_q <= '0;
            com_ptr_q   <= '0;
            free_cnt_q  <= NumEnt;
            state_q     <= StRun;
            rt_flush_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            alloc_ptr_q <= alloc_ptr_d;
            com_ptr_q   <= com_ptr_d;
            free_cnt_q  <= free_cnt_d;
            state_q     <= state_d;
            rt_flush_q  <= rt_flush_d;
            err_q       <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_dp_ptr_1 = alloc_ptr_q;
    assign o_dp_ptr_2 = alloc_ptr_q + RrfSel'(1);
    assign o_com_ptr  = com_ptr_q;
    assign o_dp_stall = (n_req != 2'd0) && !granted;
    assign o_rt_flush = rt_flush_q;
    assign o_free_cnt = free_cnt_q;
    assign o_empty    = (free_cnt_q == NumEnt);
    assign o_err      = err_q;

`ifdef RRF_ALLOC_PERF_CNT_EN
    // ------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_cnt_d    = flush_cnt_q;
        if (o_dp_stall && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        if (flush_take && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_q <= '0;
            flush_cnt_q    <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_cnt_q    <= flush_cnt_d;
        end
    end

    assign o_stall_cycles = stall_cycles_q;
    assign o_flush_cnt    = flush_cnt_q;
`endif

endmodule

// File: doc/rrf_alloc_ctrl.md
Name: rrf_alloc_ctrl

Overview:
- Allocation controller for the rename register file (RRF) entries.
- Each dispatch cycle it hands out up to two RRF tags (dp_ptr_1/2) to the renaming table and ROB.
- Tracks in-order commit, which frees entries, and stalls dispatch when entries run short.
- Sequences pipeline-flush recovery, including the one-cycle rename-table clear pulse.

Parameters:
- RRF_NUM, 64, number of RRF entries; power of two.
- RRF_SEL, 6, log2(RRF_NUM); tag width; equals `RRF_ENT_SEL.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- i_dp_req_1  in  1  dispatch slot 1 needs a tag
- i_dp_req_2  in  1  dispatch slot 2 needs a tag; legal only with i_dp_req_1
- o_dp_ptr_1  out  RRF_SEL  tag for slot 1
- o_dp_ptr_2  out  RRF_SEL  tag for slot 2
- o_dp_stall  out  1  requests not granted this cycle
- i_com_vld_1  in  1  oldest entry commits
- i_com_vld_2  in  1  second-oldest entry commits; legal only with i_com_vld_1
- o_com_ptr  out  RRF_SEL  tag of the oldest in-flight entry
- i_flush  in  1  squash all in-flight entries
- o_rt_flush  out  1  one-cycle pulse: clear renaming-table busy bits
- o_free_cnt  out  RRF_SEL+1  free entry count
- o_empty  out  1  no in-flight entries
- o_err  out  1  sticky protocol error

Behaviour:
- State: alloc_ptr and com_ptr (RRF_SEL bits each, natural wrap at RRF_NUM); free_cnt (RRF_SEL+1 bits); FSM {S_RUN, S_RECOVER}.
- Reset values: alloc_ptr=0, com_ptr=0, free_cnt=RRF_NUM, state=S_RUN, o_rt_flush=0, o_err=0.
- Ptr outputs (combinational from regs):
  - o_dp_ptr_1 = alloc_ptr.
  - o_dp_ptr_2 = alloc_ptr+1, mod RRF_NUM.
  - o_com_ptr = com_ptr.
- Request/grant (combinational):
  - n_req = i_dp_req_1 + i_dp_req_2.
  - Grant is all-or-nothing: granted iff state==S_RUN, !i_flush and free_cnt >= n_req.
  - o_dp_stall = (n_req!=0) && !granted.
  - Same-cycle commits do not count toward the grant check; free_cnt is the registered value.
- Update on each posedge, when granted and not flushing:
  - alloc_ptr += n_req.
  - com_ptr += n_com.
  - free_cnt = free_cnt - n_alloc + n_com.
  - Combined result never exceeds RRF_NUM.
- Wrap: alloc_ptr=63 with two requests gives tags 63 and 0; alloc_ptr becomes 1.
- Full (free_cnt=0): any request stalls; a commit in the same cycle frees an entry for the next cycle.
- Flush, i_flush=1 in S_RUN:
  - Commits in that cycle still apply.
  - alloc_ptr <= com_ptr + n_com.
  - free_cnt <= RRF_NUM.
  - No grant.
  - state <= S_RECOVER.
- S_RECOVER:
  - o_rt_flush=1 (registered, exactly one cycle).
  - Dispatch stalls.
  - Returns to S_RUN next cycle; i_flush held high keeps it in S_RECOVER.
- o_empty = (free_cnt==RRF_NUM).
- o_err sets on any of:
  - commit count > RRF_NUM-free_cnt;
  - i_dp_req_2 without i_dp_req_1;
  - i_com_vld_2 without i_com_vld_1.
  - It never clears except by rst.
  - On an over-commit, state does not update; pointers are held.
- Reset mid-operation: all state returns to reset values immediately (async); no pending pulse survives.

Optional Feature:
- Macro: RRF_ALLOC_PERF_CNT_EN.
- Defined:
  - Adds output o_stall_cycles[31:0], a saturating count of cycles with o_dp_stall=1.
  - Adds output o_flush_cnt[15:0], a saturating count of flushes.
  - Both reset to 0.
- Undefined: neither port exists; no counters are synthesized.

Decomposition:
- `RRF_ENT_SEL, `RRF_NUM and the FSM state encodings live in the shared constants.vh header.
- No sub-module is warranted; pointer increment, count update and FSM are one flat module.

Test Plan (RRF_NUM=64):
- Reset, then 32 cycles of dual requests → tags 0,1..62,63; free_cnt=0; 33rd dual request → o_dp_stall=1, ptrs 0/1 unchanged.
- free_cnt=1, dual request with no commit → stall; single request → grant tag alloc_ptr, free_cnt=0.
- free_cnt=0 with i_com_vld_1+i_com_vld_2 → next cycle free_cnt=2, com_ptr+=2; dual request now granted.
- alloc_ptr=10, com_ptr=4, flush with one commit → alloc_ptr=5, free_cnt=64, o_rt_flush=1 next cycle only, request stalled during S_RECOVER, granted after with tag 5.
- Empty controller, i_com_vld_1 → o_err=1 sticky, com_ptr unchanged; rst clears o_err.
- With RRF_ALLOC_PERF_CNT_EN: 7 stall cycles plus 2 flushes → o_stall_cycles=7 (recover stalls included only if requested), o_flush_cnt=2.
